// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path.
package rv32_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU, ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {
        INIT, FETCH, DECODE, EXEC, MEM, WB, TRAP
    } ctrl_state_e;

    typedef enum logic [3:0] {
        CL_ALU, CL_LUI, CL_AUIPC, CL_LOAD, CL_STORE,
        CL_BRANCH, CL_JAL, CL_JALR, CL_FENCE, CL_SYSTEM
    } instr_class_e;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_FENCE  = 7'h0F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    // Arithmetic op from funct3; alt selects SUB/SRA.
    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_decoder.sv
// Combinational IR field decode: ALU op, immediate format, class, legality.
module instr_decoder
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output alu_op_e      alu_op,
    output logic [2:0]   imm_sel,
    output instr_class_e cls,
    output logic         illegal
);

    // Opcode/funct decode with legality checks.
    always_comb begin
        alu_op  = ALU_ADD;
        imm_sel = IMM_I;
        cls     = CL_ALU;
        illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                alu_op = arith_op(funct3, funct7[5]);
                if (funct7 == 7'h20) begin
                    illegal = !((funct3 == 3'd0) || (funct3 == 3'd5));
                end else if (funct7 != 7'h00) begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                alu_op = arith_op(funct3, (funct3 == 3'd5) && funct7[5]);
                if (funct3 == 3'd1) begin
                    illegal = (funct7 != 7'h00);
                end else if (funct3 == 3'd5) begin
                    illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
                end
            end
            OPC_LUI: begin
                cls     = CL_LUI;
                alu_op  = ALU_PASSB;
                imm_sel = IMM_U;
            end
            OPC_AUIPC: begin
                cls     = CL_AUIPC;
                imm_sel = IMM_U;
            end
            OPC_LOAD: begin
                cls     = CL_LOAD;
                illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            end
            OPC_STORE: begin
                cls     = CL_STORE;
                imm_sel = IMM_S;
                illegal = (funct3 > 3'd2);
            end
            OPC_BRANCH: begin
                cls     = CL_BRANCH;
                imm_sel = IMM_B;
                case (funct3)
                    3'd0:    alu_op = ALU_EQ;
                    3'd1:    alu_op = ALU_NE;
                    3'd4:    alu_op = ALU_LT;
                    3'd5:    alu_op = ALU_GE;
                    3'd6:    alu_op = ALU_LTU;
                    3'd7:    alu_op = ALU_GEU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_JAL: begin
                cls     = CL_JAL;
                imm_sel = IMM_J;
            end
            OPC_JALR: begin
                cls     = CL_JALR;
                illegal = (funct3 != 3'd0);
            end
            OPC_FENCE:  cls = CL_FENCE;
            OPC_SYSTEM: cls = CL_SYSTEM;
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer: fetch, decode, execute, memory, write-back.
module multicycle_control_fsm
    import rv32_ctrl_pkg::*;
#(
    parameter int unsigned ALU_OP_W       = 5,
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter logic [31:0] RESET_IR       = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ready,
    input  logic                branch_taken,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [2:0]          imm_sel,
    output logic                reg_write,
    output logic [1:0]          wb_sel,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                illegal_instr,
    output logic                bus_error,
    output logic                halt,
    output logic [2:0]          state_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    ctrl_state_e      state_q, state_d;
    logic [XLEN-1:0]  ir_q;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d, wait_cnt_inc;
    logic             wait_expired;
    logic             illegal_q, bus_err_q, halt_q;
    logic             ir_load, set_illegal, set_bus_err, set_halt;
    alu_op_e          dec_alu_op;
    logic [2:0]       dec_imm_sel;
    instr_class_e     dec_cls;
    logic             dec_illegal;

    instr_decoder u_dec (
        .opcode  (ir_q[6:0]),
        .funct3  (ir_q[14:12]),
        .funct7  (ir_q[31:25]),
        .alu_op  (dec_alu_op),
        .imm_sel (dec_imm_sel),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    assign wait_cnt_inc  = wait_cnt_q + CNT_W'(1);
    assign wait_expired  = (wait_cnt_inc == CNT_W'(TIMEOUT_CYCLES));
    assign instr         = ir_q;
    assign alu_op        = ALU_OP_W'(dec_alu_op);
    assign imm_sel       = dec_imm_sel;
    assign illegal_instr = illegal_q;
    assign bus_error     = bus_err_q;
    assign halt          = halt_q;
    assign state_o       = 3'(state_q);

    // State, IR, wait counter and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            ir_q       <= RESET_IR;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (ir_load)     ir_q      <= imem_rdata;
            if (set_illegal) illegal_q <= 1'b1;
            if (set_bus_err) bus_err_q <= 1'b1;
            if (set_halt)    halt_q    <= 1'b1;
        end
    end

    // ALU operand selects follow the instruction class so they stay stable across EXEC/MEM/WB.
    always_comb begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        case (dec_cls)
            CL_ALU:   if (ir_q[6:0] == OPC_OP_IMM) alu_src_b = SRC_B_IMM;
            CL_LUI: begin
                alu_src_a = SRC_A_ZERO;
                alu_src_b = SRC_B_IMM;
            end
            CL_AUIPC: begin
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_IMM;
            end
            CL_LOAD, CL_STORE, CL_JALR: alu_src_b = SRC_B_IMM;
            default: ;
        endcase
    end

    // Next state, strobes and register-update enables.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        ir_load     = 1'b0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        set_halt    = 1'b0;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        reg_write   = 1'b0;
        wb_sel      = WB_ALU;
        pc_write    = 1'b0;
        pc_src      = PC_PLUS4;
        case (state_q)
            INIT: state_d = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = DECODE;
                end else if (wait_expired) begin
                    set_bus_err = 1'b1;
                    state_d     = TRAP;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                end
            end
            DECODE: begin
                if (dec_illegal) begin
                    set_illegal = 1'b1;
                    state_d     = TRAP;
                end else if (dec_cls == CL_SYSTEM) begin
                    set_halt = 1'b1;
                    state_d  = TRAP;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (dec_cls)
                    CL_ALU, CL_LUI, CL_AUIPC: state_d = WB;
                    CL_LOAD, CL_STORE:        state_d = MEM;
                    CL_BRANCH: begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? PC_IMM : PC_PLUS4;
                        state_d  = FETCH;
                    end
                    CL_JAL, CL_JALR: begin
                        reg_write = 1'b1;
                        wb_sel    = WB_PC4;
                        pc_write  = 1'b1;
                        pc_src    = (dec_cls == CL_JAL) ? PC_IMM : PC_JALR;
                        state_d   = FETCH;
                    end
                    CL_FENCE: begin
                        pc_write = 1'b1;
                        state_d  = FETCH;
                    end
                    default: state_d = TRAP;
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (dec_cls == CL_STORE);
                if (dmem_ready) begin
                    if (dec_cls == CL_STORE) begin
                        pc_write = 1'b1;
                        state_d  = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (wait_expired) begin
                    set_bus_err = 1'b1;
                    state_d     = TRAP;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                end
            end
            WB: begin
                reg_write = 1'b1;
                wb_sel    = (dec_cls == CL_LOAD) ? WB_MEM : WB_ALU;
                pc_write  = 1'b1;
                state_d   = FETCH;
            end
            TRAP: ;
            default: state_d = INIT;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed scoreboard bench for multicycle_control_fsm.
module tb_multicycle_control_fsm;
    import rv32_ctrl_pkg::*;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       illegal;
        logic       bus_err;
        logic       halt;
        logic [4:0] alu_op;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] imm_sel;
    } obs_t;

    typedef struct {
        obs_t  v;
        logic  care;
        string tag;
    } sb_t;

    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_IREQ = 5'b10000;
    localparam logic [4:0] S_DREQ = 5'b01000;
    localparam logic [4:0] S_DWE  = 5'b00100;
    localparam logic [4:0] S_RW   = 5'b00010;
    localparam logic [4:0] S_PW   = 5'b00001;

    localparam logic [31:0] I_ADD  = 32'h0020_81B3;
    localparam logic [31:0] I_LW   = 32'h0080_A283;
    localparam logic [31:0] I_SW   = 32'h0020_A223;
    localparam logic [31:0] I_BEQ  = 32'h0020_8463;
    localparam logic [31:0] I_BLTU = 32'h0020_E463;
    localparam logic [31:0] I_JALR = 32'h0001_00E7;
    localparam logic [31:0] I_LUI  = 32'h1234_52B7;
    localparam logic [31:0] I_BAD  = 32'hFFFF_FFFF;
    localparam logic [31:0] I_ECALL = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ready;
    logic [31:0] imem_rdata, instr;
    logic        dmem_req, dmem_we, dmem_ready, branch_taken;
    logic [4:0]  alu_op;
    logic [1:0]  alu_src_a, alu_src_b, wb_sel, pc_src;
    logic [2:0]  imm_sel, state_o;
    logic        reg_write, pc_write, illegal_instr, bus_error, halt;

    int vectors = 0;
    int miscompares = 0;
    sb_t sb_q[$];

    multicycle_control_fsm #(
        .ALU_OP_W(5), .TIMEOUT_CYCLES(15), .RESET_IR(32'h0000_0013)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .branch_taken(branch_taken),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_sel(imm_sel),
        .reg_write(reg_write), .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src),
        .illegal_instr(illegal_instr), .bus_error(bus_error), .halt(halt),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic obs_t ex(input ctrl_state_e s, input logic [4:0] stb,
                                input logic [1:0] wbs, input logic [1:0] pcs,
                                input logic [2:0] flg);
        obs_t e = '0;
        e.st = 3'(s);
        {e.imem_req, e.dmem_req, e.dmem_we, e.reg_write, e.pc_write} = stb;
        e.wb_sel = wbs;
        e.pc_src = pcs;
        {e.illegal, e.bus_err, e.halt} = flg;
        return e;
    endfunction

    function automatic obs_t al(input obs_t e, input alu_op_e op, input logic [1:0] a,
                                input logic [1:0] b, input logic [2:0] isel);
        obs_t r = e;
        r.alu_op  = 5'(op);
        r.src_a   = a;
        r.src_b   = b;
        r.imm_sel = isel;
        return r;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = state_o;
        o.imem_req = imem_req;
        o.dmem_req = dmem_req;
        o.dmem_we = dmem_we;
        o.reg_write = reg_write;
        o.wb_sel = wb_sel;
        o.pc_write = pc_write;
        o.pc_src = pc_src;
        o.illegal = illegal_instr;
        o.bus_err = bus_error;
        o.halt = halt;
        o.alu_op = alu_op;
        o.src_a = alu_src_a;
        o.src_b = alu_src_b;
        o.imm_sel = imm_sel;
        return o;
    endfunction

    task automatic push_exp(input string tag, input obs_t e, input logic care);
        sb_t x;
        x.v = e;
        x.care = care;
        x.tag = tag;
        sb_q.push_back(x);
    endtask

    // Pop the oldest expectation and compare against the DUT now.
    task automatic check();
        sb_t  x;
        obs_t o;
        x = sb_q.pop_front();
        o = sample();
        if (!x.care) begin
            o.alu_op = '0;   o.src_a = '0;   o.src_b = '0;   o.imm_sel = '0;
            x.v.alu_op = '0; x.v.src_a = '0; x.v.src_b = '0; x.v.imm_sel = '0;
        end
        vectors++;
        assert (o === x.v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", x.tag, o, x.v);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs after the falling edge, then check the current state.
    task automatic step(input string tag, input logic ir, input logic [31:0] rd,
                        input logic dr, input logic bt, input obs_t e, input logic care);
        @(negedge clk);
        imem_ready   = ir;
        imem_rdata   = rd;
        dmem_ready   = dr;
        branch_taken = bt;
        push_exp(tag, e, care);
        #1;
        check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        dmem_ready = 1'b0;
        branch_taken = 1'b0;

        // Reset state
        step("reset", 1'b0, '0, 1'b0, 1'b0, ex(INIT, S_NONE, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
        chk32("reset_ir", instr, 32'h0000_0013);
        rst_n = 1'b1;

        // ADD x3,x1,x2
        step("add_fetch", 1'b1, I_ADD, 1'b0, 1'b0, ex(FETCH, S_IREQ, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
        step("add_decode", 1'b0, '0, 1'b0, 1'b0, ex(DECODE, S_NONE, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
        chk32("add_ir", instr, I_ADD);
        step("add_exec", 1'b0, '0, 1'b0, 1'b0,
             al(ex(EXEC, S_NONE, WB_ALU, PC_PLUS4, 3'b000), ALU_ADD, SRC_A_RS1, SRC_B_RS2, IMM_I), 1'b1);
        step("add_wb", 1'b0, '0, 1'b0, 1'b0,
             al(ex(WB, S_RW | S_PW, WB_ALU, PC_PLUS4, 3'b000), ALU_ADD, SRC_A_RS1, SRC_B_RS2, IMM_I), 1'b1);

        // LW x5,8(x1) with three data wait states
        step("lw_fetch", 1'b1, I_LW, 1'b0, 1'b0, ex(FETCH, S_IREQ, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
        step("lw_decode", 1'b0, '0, 1'b0, 1'b0, ex(DECODE, S_NONE, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
        step("lw_exec", 1'b0, '0, 1'b0, 1'b0,
             al(ex(EXEC, S_NONE, WB_ALU, PC_PLUS4, 3'b000), ALU_ADD, SRC_A_RS1, SRC_B_IMM, IMM_I), 1'b1);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("lw_mem%0d", i), 1'b0, '0, (i == 3), 1'b0,
                 al(ex(MEM, S_DREQ, WB_ALU, PC_PLUS4, 3'b000), ALU_ADD, SRC_A_RS1, SRC_B_IMM, IMM_I), 1'b1);
        end
        step("lw_wb", 1'b0, '0, 1'b0, 1'b0,
             al(ex(WB, S_RW | S_PW, WB_MEM, PC_PLUS4, 3'b000), ALU_ADD, SRC_A_RS1, SRC_B_IMM, IMM_I), 1'b1);

        // SW x2,4(x1), zero wait
        step("sw_fetch", 1'b1, I_SW, 1'b0, 1'b0, ex(FETCH, S_IREQ, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
        step("sw_decode", 1'b0, '0, 1'b0, 1'b0, ex(DECODE, S_NONE, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
        step("sw_exec", 1'b0, '0, 1'b0, 1'b0,
             al(ex(EXEC, S_NONE, WB_ALU, PC_PLUS4, 3'b000), ALU_ADD, SRC_A_RS1, SRC_B_IMM, IMM_S), 1'b1);
        step("sw_mem", 1'b0, '0, 1'b1, 1'b0,
             al(ex(MEM, S_DREQ | S_DWE | S_PW, WB_ALU, PC_PLUS4, 3'b000), ALU_ADD, SRC_A_RS1, SRC_B_IMM, IMM_S), 1'b1);

        // BEQ taken / not taken, BLTU taken
        for (int k = 0; k < 3; k++) begin
            logic [31:0] bi;
            alu_op_e     bop;
            logic        bt;
            bi  = (k == 2) ? I_BLTU : I_BEQ;
            bop = (k == 2) ? ALU_LTU : ALU_EQ;
            bt  = (k != 1);
            step($sformatf("br%0d_fetch", k), 1'b1, bi, 1'b0, 1'b0,
                 ex(FETCH, S_IREQ, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
            step($sformatf("br%0d_decode", k), 1'b0, '0, 1'b0, 1'b0,
                 ex(DECODE, S_NONE, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
            step($sformatf("br%0d_exec", k), 1'b0, '0, 1'b0, bt,
                 al(ex(EXEC, S_PW, WB_ALU, bt ? PC_IMM : PC_PLUS4, 3'b000), bop, SRC_A_RS1, SRC_B_RS2, IMM_B), 1'b1);
        end

        // JALR x1,0(x2): single EXEC cycle then straight back to FETCH
        step("jalr_fetch", 1'b1, I_JALR, 1'b0, 1'b0, ex(FETCH, S_IREQ, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
        step("jalr_decode", 1'b0, '0, 1'b0, 1'b0, ex(DECODE, S_NONE, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
        step("jalr_exec", 1'b0, '0, 1'b0, 1'b0,
             al(ex(EXEC, S_RW | S_PW, WB_PC4, PC_JALR, 3'b000), ALU_ADD, SRC_A_RS1, SRC_B_IMM, IMM_I), 1'b1);

        // LUI x5,0x12345
        step("lui_fetch", 1'b1, I_LUI, 1'b0, 1'b0, ex(FETCH, S_IREQ, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
        step("lui_decode", 1'b0, '0, 1'b0, 1'b0, ex(DECODE, S_NONE, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
        step("lui_exec", 1'b0, '0, 1'b0, 1'b0,
             al(ex(EXEC, S_NONE, WB_ALU, PC_PLUS4, 3'b000), ALU_PASSB, SRC_A_ZERO, SRC_B_IMM, IMM_U), 1'b1);
        step("lui_wb", 1'b0, '0, 1'b0, 1'b0,
             al(ex(WB, S_RW | S_PW, WB_ALU, PC_PLUS4, 3'b000), ALU_PASSB, SRC_A_ZERO, SRC_B_IMM, IMM_U), 1'b1);

        // Illegal instruction: trap holds with strobes low while inputs toggle
        step("bad_fetch", 1'b1, I_BAD, 1'b0, 1'b0, ex(FETCH, S_IREQ, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
        step("bad_decode", 1'b1, '0, 1'b1, 1'b1, ex(DECODE, S_NONE, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step($sformatf("bad_trap%0d", i), 1'b1, I_ADD, 1'b1, 1'b1,
                 ex(TRAP, S_NONE, WB_ALU, PC_PLUS4, 3'b100), 1'b0);
        end

        // Asynchronous reset mid-cycle clears the sticky flag without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        push_exp("async_reset", ex(INIT, S_NONE, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
        check();
        step("reset_hold", 1'b0, '0, 1'b0, 1'b0, ex(INIT, S_NONE, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
        rst_n = 1'b1;

        // Fetch timeout: 15 request cycles without ready, then trap
        for (int i = 0; i < 15; i++) begin
            step($sformatf("to_fetch%0d", i), 1'b0, '0, 1'b0, 1'b0,
                 ex(FETCH, S_IREQ, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
        end
        step("to_trap", 1'b1, '0, 1'b0, 1'b0, ex(TRAP, S_NONE, WB_ALU, PC_PLUS4, 3'b010), 1'b0);
        step("to_trap_hold", 1'b1, '0, 1'b0, 1'b0, ex(TRAP, S_NONE, WB_ALU, PC_PLUS4, 3'b010), 1'b0);

        // Reset, then ready lands on the limit cycle: accepted, ECALL halts
        rst_n = 1'b0;
        step("reset2", 1'b0, '0, 1'b0, 1'b0, ex(INIT, S_NONE, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step($sformatf("lim_fetch%0d", i), (i == 14), I_ECALL, 1'b0, 1'b0,
                 ex(FETCH, S_IREQ, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
        end
        step("ecall_decode", 1'b0, '0, 1'b0, 1'b0, ex(DECODE, S_NONE, WB_ALU, PC_PLUS4, 3'b000), 1'b0);
        chk32("ecall_ir", instr, I_ECALL);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("halt_trap%0d", i), 1'b1, '0, 1'b1, 1'b0,
                 ex(TRAP, S_NONE, WB_ALU, PC_PLUS4, 3'b001), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle sequencer for the RV32I core, replacing the single-cycle combinational decoder.
- Fetches through a req/ready instruction port and latches the instruction register (IR).
- Drives the datapath through FETCH/DECODE/EXEC/MEM/WB, with a req/ready data-memory handshake.
- Adds full unsigned compare/branch decode, JALR/AUIPC select, illegal-instruction detection, ECALL/EBREAK halt and a bus-timeout trap.

Parameters:
ALU_OP_W, 5, width of alu_op; encodings live in the shared package.
TIMEOUT_CYCLES, 15, maximum wait cycles on imem/dmem before trapping with bus_error.
RESET_IR, 32'h0000_0013, IR value after reset (NOP).

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active low
imem_req  out  1  instruction fetch request
imem_ready  in  1  fetch complete; imem_rdata valid
imem_rdata  in  32  fetched instruction
instr  out  32  latched IR, for the immediate generator and register-file addresses
dmem_req  out  1  data access request
dmem_we  out  1  1 = store, 0 = load (valid while dmem_req)
dmem_ready  in  1  data access complete
branch_taken  in  1  ALU compare result
alu_op  out  ALU_OP_W  ALU operation
alu_src_a  out  2  0 = rs1, 1 = PC, 2 = zero
alu_src_b  out  2  0 = rs2, 1 = imm, 2 = constant 4
imm_sel  out  3  I/S/B/U/J immediate format
reg_write  out  1  register-file write strobe
wb_sel  out  2  0 = ALU, 1 = memory, 2 = PC+4
pc_write  out  1  PC update strobe
pc_src  out  2  0 = PC+4, 1 = PC+imm, 2 = (rs1+imm) & ~1
illegal_instr  out  1  sticky illegal-instruction flag
bus_error  out  1  sticky timeout flag
halt  out  1  ECALL/EBREAK reached; core stopped
state_o  out  3  current state (debug)

Behaviour:
- Reset (rst_n low, asynchronous): state = INIT, IR = RESET_IR, wait counter = 0, sticky flags = 0.
- All strobes (imem_req, dmem_req, reg_write, pc_write) are 0 in INIT. INIT goes to FETCH on the first clock edge after release.
- Outputs are decoded combinationally from state and IR. Only state, IR, counter and flags are registered.
- FETCH:
  - imem_req = 1, held until imem_ready.
  - imem_ready in the first request cycle is accepted.
  - On ready: IR <= imem_rdata, go to DECODE, counter cleared.
- DECODE: one cycle.
  - Illegal encoding: set illegal_instr, go to TRAP.
  - Opcode 0x73: set halt, go to TRAP.
  - Otherwise go to EXEC.
- Illegal encodings:
  - unknown opcode;
  - R-type funct7 not 0x00/0x20, or 0x20 with funct3 not in {0, 5};
  - SLLI/SRLI/SRAI with bad funct7;
  - branch funct3 010/011;
  - load funct3 011/110/111;
  - store funct3 > 2;
  - JALR funct3 != 0.
- EXEC:
  - R-type / OP-IMM / LUI / AUIPC: go to WB.
    - LUI: alu_op = PASSB, src_b = imm.
    - AUIPC: src_a = PC, src_b = imm.
  - Load/store: alu_op = ADD, src_b = imm, go to MEM.
  - Branch: alu_op = EQ/NE/LT/GE/LTU/GEU from funct3; pc_write = 1; pc_src = branch_taken ? 1 : 0; go to FETCH.
  - JAL/JALR: reg_write = 1, wb_sel = 2, pc_write = 1, pc_src = 1 (JAL) or 2 (JALR), all in the same cycle; go to FETCH.
  - FENCE: pc_write = 1, pc_src = 0, go to FETCH.
- MEM:
  - dmem_req = 1, held until dmem_ready; dmem_we and ALU controls stable while waiting.
  - Load: go to WB.
  - Store: pc_write = 1, pc_src = 0 in the ready cycle, then go to FETCH.
- WB: reg_write = 1, wb_sel = 0 (ALU) or 1 (load), pc_write = 1, pc_src = 0, go to FETCH.
- rd = x0 is still strobed; the register file discards the write.
- Latency with zero wait states (fetch through PC update): ALU/LUI/AUIPC 4 cycles, load 5, store 4, branch/JAL/JALR/FENCE 3. Each memory wait cycle adds 1.
- Timeout:
  - The counter increments on each FETCH/MEM cycle without ready.
  - When the counter reaches TIMEOUT_CYCLES without ready: set bus_error, drop the request, go to TRAP.
  - Ready arriving in the same cycle as the limit wins (no trap).
- TRAP: all strobes 0; held until reset. Sticky flags are cleared only by reset.
- Reset mid-transaction: requests drop asynchronously; the outstanding access is abandoned.

Decomposition:
- Package rv32_ctrl_pkg holds:
  - alu_op_e: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND EQ NE LT GE LTU GEU PASSB;
  - ctrl_state_e: INIT FETCH DECODE EXEC MEM WB TRAP;
  - opcode constants, imm_sel / wb_sel / pc_src encodings.
- Sub-module instr_decoder: combinational IR to alu_op, imm_sel, class and illegal.
- The FSM, counter and IR register stay in the top module.

Test Plan:
- Reset, release, imem_ready = 1, rdata 0x002081B3 (ADD x3,x1,x2) -> states INIT, FETCH, DECODE, EXEC, WB; alu_op = ADD; reg_write = 1 and pc_write = 1 with pc_src = 0 in the WB cycle only.
- 0x0080A283 (LW x5,8(x1)) with dmem_ready delayed 3 cycles -> dmem_req = 1 and dmem_we = 0 for 4 cycles; WB has wb_sel = 1; 8 cycles total.
- 0x00208463 (BEQ x1,x2,8): branch_taken = 1 -> pc_write = 1, pc_src = 1. Repeat with branch_taken = 0 -> pc_src = 0. Same with funct3 = 110 -> alu_op = LTU.
- 0x000100E7 (JALR x1,0(x2)) -> a single EXEC cycle with reg_write = 1, wb_sel = 2, pc_write = 1, pc_src = 2.
- rdata 0xFFFFFFFF -> illegal_instr = 1 after DECODE, state TRAP, strobes 0 for 20+ cycles; rst_n pulse clears the flag.
- imem_ready held 0 -> bus_error after 15 wait cycles. Rerun with ready arriving exactly at cycle 15 -> no trap. Then 0x00000073 -> halt = 1.
